// File: rtl/uart_tx_engine_if.sv
// FIFO-side and line-side signals of the UART transmit engine.
// The master modport is the engine; the slave modport is the FIFO, enable and line side.
interface uart_tx_engine_if #(
  parameter int WIDTH = 8
);
  logic             tx_en;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_rd_en;
  logic             txd;
  logic             busy;
  logic             tx_done;

  modport master (
    input  tx_en,
    input  fifo_empty,
    input  fifo_data,
    output fifo_rd_en,
    output txd,
    output busy,
    output tx_done
  );

  modport slave (
    output tx_en,
    output fifo_empty,
    output fifo_data,
    input  fifo_rd_en,
    input  txd,
    input  busy,
    input  tx_done
  );
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmit engine: pops one word per frame from the FIFO and shifts it out LSB-first
// as start bit, WIDTH data bits, optional parity bit and NSTOP stop bits.
module uart_tx_engine #(
  parameter int WIDTH      = 8,
  parameter int CLKDIV     = 868,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int NSTOP      = 1
) (
  input logic               clk,
  input logic               rst,
  uart_tx_engine_if.master  bus
);

  localparam int BAUD_W = $clog2(CLKDIV);
  localparam int BIT_W  = $clog2(WIDTH + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKDIV - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(WIDTH - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(NSTOP - 1);
  localparam logic              ODD_BIT   = (PARITY_ODD != 0);
  localparam logic              HAS_PAR   = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t             state_reg,  state_next;
  logic [BAUD_W-1:0]  baud_reg,   baud_next;
  logic [BIT_W-1:0]   bit_reg,    bit_next;
  logic [WIDTH-1:0]   shift_reg,  shift_next;
  logic               parity_reg, parity_next;
  logic               txd_reg,    txd_next;
  logic               rd_en_reg,  rd_en_next;
  logic               busy_reg,   busy_next;
  logic               done_reg,   done_next;

  logic               baud_wrap;

  assign baud_wrap = (baud_reg == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      baud_reg   <= '0;
      bit_reg    <= '0;
      shift_reg  <= '0;
      parity_reg <= 1'b0;
      txd_reg    <= 1'b1;
      rd_en_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      baud_reg   <= baud_next;
      bit_reg    <= bit_next;
      shift_reg  <= shift_next;
      parity_reg <= parity_next;
      txd_reg    <= txd_next;
      rd_en_reg  <= rd_en_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
    end
  end

  // All outputs are registered: each *_next value is what the line shows in the next state.
  always_comb begin
    state_next  = state_reg;
    baud_next   = baud_reg;
    bit_next    = bit_reg;
    shift_next  = shift_reg;
    parity_next = parity_reg;
    txd_next    = txd_reg;
    rd_en_next  = 1'b0;
    done_next   = 1'b0;

    case (state_reg)
      S_IDLE: begin
        txd_next = 1'b1;
        if (bus.tx_en && !bus.fifo_empty) begin
          state_next = S_FETCH;
          rd_en_next = 1'b1;
        end
      end

      S_FETCH: begin
        state_next = S_LOAD;
      end

      S_LOAD: begin
        shift_next  = bus.fifo_data;
        parity_next = (^bus.fifo_data) ^ ODD_BIT;
        bit_next    = '0;
        baud_next   = '0;
        txd_next    = 1'b0;
        state_next  = S_START;
      end

      S_START: begin
        baud_next = baud_wrap ? '0 : baud_reg + BAUD_W'(1);
        if (baud_wrap) begin
          state_next = S_DATA;
          bit_next   = '0;
          txd_next   = shift_reg[0];
          shift_next = shift_reg >> 1;
        end
      end

      S_DATA: begin
        baud_next = baud_wrap ? '0 : baud_reg + BAUD_W'(1);
        if (baud_wrap) begin
          if (bit_reg == DATA_LAST) begin
            bit_next = '0;
            if (HAS_PAR) begin
              state_next = S_PARITY;
              txd_next   = parity_reg;
            end else begin
              state_next = S_STOP;
              txd_next   = 1'b1;
            end
          end else begin
            bit_next   = bit_reg + BIT_W'(1);
            txd_next   = shift_reg[0];
            shift_next = shift_reg >> 1;
          end
        end
      end

      S_PARITY: begin
        baud_next = baud_wrap ? '0 : baud_reg + BAUD_W'(1);
        if (baud_wrap) begin
          state_next = S_STOP;
          bit_next   = '0;
          txd_next   = 1'b1;
        end
      end

      S_STOP: begin
        baud_next = baud_wrap ? '0 : baud_reg + BAUD_W'(1);
        txd_next  = 1'b1;
        if (baud_wrap) begin
          if (bit_reg == STOP_LAST) begin
            state_next = S_IDLE;
            bit_next   = '0;
            done_next  = 1'b1;
          end else begin
            bit_next = bit_reg + BIT_W'(1);
          end
        end
      end

      default: begin
        state_next = S_IDLE;
        txd_next   = 1'b1;
      end
    endcase

    busy_next = (state_next != S_IDLE);
  end

  assign bus.fifo_rd_en = rd_en_reg;
  assign bus.txd        = txd_reg;
  assign bus.busy       = busy_reg;
  assign bus.tx_done    = done_reg;

endmodule

// File: doc/uart_tx_engine.md
# uart_tx_engine

Serial transmit stage of the UART controller: it drains words from the transmit `fifo`, serialises each one and drives the `txd` line LSB-first. Each frame is one start bit, WIDTH data bits, an optional parity bit and NSTOP stop bits. The block connects directly to the FIFO's `rd_en`/`empty`/`odata` ports and is the FIFO's only reader.

## Interface
- WIDTH, 8, data bits per frame; must match FIFO WIDTH.
- CLKDIV, 868, clocks per bit period (100 MHz / 115200); legal range ≥ 2.
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, 0 selects even parity, 1 selects odd; ignored when PARITY_EN=0.
- NSTOP, 1, number of stop bits (1 or 2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- tx_en  in  1  transmit enable; sampled only in IDLE.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  WIDTH  FIFO odata; valid in the cycle after `fifo_rd_en` is high.
- fifo_rd_en  out  1  registered one-cycle read strobe to the FIFO.
- txd  out  1  serial output; idles high.
- busy  out  1  high from FETCH through the last stop-bit cycle.
- tx_done  out  1  one-cycle pulse after the final stop bit.

## Operation
- States are IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE → FETCH when tx_en=1 and fifo_empty=0; otherwise the block stays in IDLE.
- FETCH lasts exactly 1 cycle with fifo_rd_en=1, then goes to LOAD.
- LOAD lasts 1 cycle. At its end the block latches fifo_data into the shift register, clears the bit counter and baud counter, and sets txd to 0. Next state is START.
- START, DATA, PARITY and STOP each hold for CLKDIV cycles per bit. The baud counter counts 0..CLKDIV-1 and wraps; the wrap marks the end of a bit.
- DATA shifts out WIDTH bits, LSB first, in the order data[0]..data[WIDTH-1].
- PARITY is entered only when PARITY_EN=1. The parity bit is the XOR of all data bits, XORed with PARITY_ODD.
- STOP drives txd=1 for NSTOP·CLKDIV cycles. On the final wrap: tx_done=1 for 1 cycle, busy=0, and the state returns to IDLE.
- Counter widths: baud counter is $clog2(CLKDIV) bits; bit counter is $clog2(WIDTH+1) bits. There is no overflow path, because both counters are compared with `==` before they can wrap.
- fifo_rd_en is never asserted while fifo_empty=1 is sampled. At most one read is issued per frame.
- tx_en deasserted mid-frame: the current frame completes normally, and no further fetch occurs.
- Reset (any state, including mid-frame):
  - next cycle: state=IDLE, txd=1, fifo_rd_en=0, busy=0, tx_done=0, all counters and the shift register 0;
  - the in-flight word is discarded and is not re-read.

## Timing
- Cycle t: IDLE with tx_en=1 and fifo_empty=0.
- t+1: FETCH, fifo_rd_en=1, busy=1.
- t+2: LOAD, fifo_data is sampled.
- t+3: txd=0, first cycle of the start bit.
- Start-bit latency from the IDLE decision is 3 cycles.
- Frame duration on txd: (1 + WIDTH + PARITY_EN + NSTOP)·CLKDIV cycles, with no jitter.
- tx_done is high in the cycle after the last stop-bit cycle, which is also the IDLE cycle.
- Back-to-back gap with the FIFO non-empty: the IDLE, FETCH and LOAD cycles hold txd=1. Each new start bit therefore begins 3 cycles after the previous stop bit ends.
- busy is low only in IDLE.

## Test plan
- **Single word.** CLKDIV=4, WIDTH=8, no parity; push 0xA5. Required: txd = 0,1,0,1,0,0,1,0,1,1, each level held for exactly 4 cycles; one fifo_rd_en pulse; tx_done pulse 40 cycles after the start bit begins.
- **Even parity.** PARITY_EN=1, PARITY_ODD=0, send 0x07: parity bit 1. Repeat with PARITY_ODD=1: parity bit 0. Frame is 11 bit periods.
- **Back-to-back.** Push 0x01, 0x80 with NSTOP=2. Required: two frames; exactly 3 high cycles between the second stop bit of frame 1 and the start of frame 2; two rd_en pulses; FIFO ends empty.
- **Empty / disabled.** fifo_empty=1 held for 100 cycles, then tx_en=0 with data present. Required: fifo_rd_en never high, txd=1, busy=0 throughout.
- **Reset mid-frame.** Assert rst during DATA bit 3 of 0x55. Required: next cycle txd=1, busy=0; no tx_done. After release, the next queued word transmits intact.
- **tx_en drop.** Deassert tx_en mid-frame with 2 words queued. Required: the current frame completes with tx_done; the second word is not fetched until tx_en=1.
